// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//   Execution datapath driven by the processor control unit's per-cycle
//   control word. It holds a 2^RF_AW x DATA_W register file (two combinational
//   read ports, one write port), an 8-function ALU, a write-back mux and a
//   2^MEM_AW x DATA_W data RAM with one-cycle registered read data.
//
// Ports
//   Clock       : system clock, all state updates on its rising edge
//   Reset       : synchronous reset, active-low
//   D_addr      : data RAM address (read every cycle, write when D_wr=1)
//   D_wr        : data RAM write enable, store data comes from read port A
//   RF_s        : write-back select, 1 = Mem_rdata, 0 = Alu_out
//   RF_W_addr   : register file write address
//   RF_W_wr     : register file write enable
//   RF_Ra_addr  : read port A address
//   RF_Ra_rd    : read port A enable (port reads 0 when low)
//   RF_Rb_addr  : read port B address
//   RF_Rb_rd    : read port B enable (port reads 0 when low)
//   Alu_s0      : ALU function select
//   Ra_data     : read port A data (combinational)
//   Rb_data     : read port B data (combinational)
//   Alu_out     : ALU result (combinational)
//   W_data      : write-back mux output
//   Mem_rdata   : registered RAM read data
//   Zero        : registered zero flag of the last register file write
// ---------------------------------------------------------------------------
module datapath #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4,
    parameter int MEM_AW = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [MEM_AW-1:0] D_addr,
    input  logic              D_wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic              RF_W_wr,
    input  logic [RF_AW-1:0]  RF_Ra_addr,
    input  logic              RF_Ra_rd,
    input  logic [RF_AW-1:0]  RF_Rb_addr,
    input  logic              RF_Rb_rd,
    input  logic [2:0]        Alu_s0,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic [DATA_W-1:0] Alu_out,
    output logic [DATA_W-1:0] W_data,
    output logic [DATA_W-1:0] Mem_rdata,
    output logic              Zero
);

    localparam int RF_N  = 1 << RF_AW;
    localparam int MEM_N = 1 << MEM_AW;

    localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] rf_r  [RF_N];
    logic [DATA_W-1:0] ram_r [MEM_N];
    logic [DATA_W-1:0] mem_rdata_r;
    logic              zero_r;

    logic [DATA_W-1:0] ra_data_s;
    logic [DATA_W-1:0] rb_data_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] w_data_s;

    // Register file read ports: a disabled port drives zero onto the bus.
    always_comb begin
        ra_data_s = ZERO_W;
        rb_data_s = ZERO_W;
        if (RF_Ra_rd) begin
            ra_data_s = rf_r[RF_Ra_addr];
        end else begin
            ra_data_s = ZERO_W;
        end
        if (RF_Rb_rd) begin
            rb_data_s = rf_r[RF_Rb_addr];
        end else begin
            rb_data_s = ZERO_W;
        end
    end

    // ALU: unsigned, results truncated to DATA_W so carries fall off.
    always_comb begin
        alu_s = ZERO_W;
        case (Alu_s0)
            3'd0:    alu_s = ZERO_W;
            3'd1:    alu_s = ra_data_s + rb_data_s;
            3'd2:    alu_s = ra_data_s - rb_data_s;
            3'd3:    alu_s = ra_data_s;
            3'd4:    alu_s = ra_data_s ^ rb_data_s;
            3'd5:    alu_s = ra_data_s | rb_data_s;
            3'd6:    alu_s = ra_data_s & rb_data_s;
            3'd7:    alu_s = ra_data_s + ONE_W;
            default: alu_s = ZERO_W;
        endcase
    end

    // Write-back mux between the loaded RAM word and the ALU result.
    always_comb begin
        w_data_s = ZERO_W;
        if (RF_s) begin
            w_data_s = mem_rdata_r;
        end else begin
            w_data_s = alu_s;
        end
    end

    // Register file write port; reset clears every entry and suppresses the write.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < RF_N; i++) begin
                rf_r[i] <= ZERO_W;
            end
        end else if (RF_W_wr) begin
            rf_r[RF_W_addr] <= w_data_s;
        end else begin
            rf_r[RF_W_addr] <= rf_r[RF_W_addr];
        end
    end

    // Data RAM array: contents survive reset, only the store is suppressed.
    always_ff @(posedge Clock) begin
        if (Reset && D_wr) begin
            ram_r[D_addr] <= ra_data_s;
        end
    end

    // RAM read register: samples the pre-write word so a same-address store
    // becomes visible one cycle later.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            mem_rdata_r <= ZERO_W;
        end else begin
            mem_rdata_r <= ram_r[D_addr];
        end
    end

    // Zero flag follows register file writes only and holds otherwise.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            zero_r <= 1'b0;
        end else if (RF_W_wr) begin
            zero_r <= (w_data_s == ZERO_W);
        end else begin
            zero_r <= zero_r;
        end
    end

    assign Ra_data   = ra_data_s;
    assign Rb_data   = rb_data_s;
    assign Alu_out   = alu_s;
    assign W_data    = w_data_s;
    assign Mem_rdata = mem_rdata_r;
    assign Zero      = zero_r;

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
//   Self-checking bench for datapath. Each vector carries one cycle's control
//   word, the expected combinational outputs before the edge and the expected
//   registered outputs after it. Registered expectations go through a
//   scoreboard queue that is drained after the rising edge.
// ---------------------------------------------------------------------------
module tb_datapath;

    logic        Clock;
    logic        Reset;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Ra_addr;
    logic        RF_Ra_rd;
    logic [3:0]  RF_Rb_addr;
    logic        RF_Rb_rd;
    logic [2:0]  Alu_s0;
    logic [15:0] Ra_data;
    logic [15:0] Rb_data;
    logic [15:0] Alu_out;
    logic [15:0] W_data;
    logic [15:0] Mem_rdata;
    logic        Zero;

    datapath dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Ra_rd   (RF_Ra_rd),
        .RF_Rb_addr (RF_Rb_addr),
        .RF_Rb_rd   (RF_Rb_rd),
        .Alu_s0     (Alu_s0),
        .Ra_data    (Ra_data),
        .Rb_data    (Rb_data),
        .Alu_out    (Alu_out),
        .W_data     (W_data),
        .Mem_rdata  (Mem_rdata),
        .Zero       (Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rst;
        logic [3:0]  ra;
        logic        ra_rd;
        logic [3:0]  rb;
        logic        rb_rd;
        logic [2:0]  s0;
        logic        rf_s;
        logic [3:0]  w;
        logic        w_wr;
        logic [7:0]  daddr;
        logic        d_wr;
        logic [15:0] e_ra;
        logic [15:0] e_rb;
        logic [15:0] e_alu;
        logic [15:0] e_w;
        logic        e_zero;
        logic        chk_mrd;
        logic [15:0] e_mrd;
    } vec_t;

    typedef struct {
        logic        zero;
        logic        chk_mrd;
        logic [15:0] mrd;
        int          row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   row_n    = 0;

    function automatic vec_t mk(int rst, int ra, int ra_rd, int rb, int rb_rd, int s0,
                                int rf_s, int w, int w_wr, int daddr, int d_wr,
                                int e_ra, int e_rb, int e_alu, int e_w, int e_zero,
                                int chk_mrd, int e_mrd);
        vec_t v;
        v.rst     = rst[0];
        v.ra      = ra[3:0];
        v.ra_rd   = ra_rd[0];
        v.rb      = rb[3:0];
        v.rb_rd   = rb_rd[0];
        v.s0      = s0[2:0];
        v.rf_s    = rf_s[0];
        v.w       = w[3:0];
        v.w_wr    = w_wr[0];
        v.daddr   = daddr[7:0];
        v.d_wr    = d_wr[0];
        v.e_ra    = e_ra[15:0];
        v.e_rb    = e_rb[15:0];
        v.e_alu   = e_alu[15:0];
        v.e_w     = e_w[15:0];
        v.e_zero  = e_zero[0];
        v.chk_mrd = chk_mrd[0];
        v.e_mrd   = e_mrd[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs, then the registered ones.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge Clock);
        Reset      = v.rst;
        RF_Ra_addr = v.ra;
        RF_Ra_rd   = v.ra_rd;
        RF_Rb_addr = v.rb;
        RF_Rb_rd   = v.rb_rd;
        Alu_s0     = v.s0;
        RF_s       = v.rf_s;
        RF_W_addr  = v.w;
        RF_W_wr    = v.w_wr;
        D_addr     = v.daddr;
        D_wr       = v.d_wr;
        #1;
        chk("ra_data", row_n, Ra_data, v.e_ra);
        chk("rb_data", row_n, Rb_data, v.e_rb);
        chk("alu_out", row_n, Alu_out, v.e_alu);
        chk("w_data",  row_n, W_data,  v.e_w);
        e.zero    = v.e_zero;
        e.chk_mrd = v.chk_mrd;
        e.mrd     = v.e_mrd;
        e.row     = row_n;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty row %0d: got 0 entries expected 1", row_n);
        end else begin
            got = sb.pop_front();
            chk("zero", got.row, {15'd0, Zero}, {15'd0, got.zero});
            if (got.chk_mrd) chk("mem_rdata", got.row, Mem_rdata, got.mrd);
        end
        row_n++;
    endtask

    // Build value val into register r (currently 0) by doubling and incrementing.
    task automatic build(input int r, input logic [15:0] val);
        int acc;
        acc = 0;
        for (int i = 15; i >= 0; i--) begin
            if (acc != 0) begin
                apply(mk(1, r, 1, r, 1, 1, 0, r, 1, 0, 0,
                         acc, acc, (acc * 2) & 16'hFFFF, (acc * 2) & 16'hFFFF, 0, 0, 0));
                acc = (acc * 2) & 16'hFFFF;
            end
            if (val[i]) begin
                apply(mk(1, r, 1, 0, 0, 7, 0, r, 1, 0, 0, acc, 0, acc + 1, acc + 1, 0, 0, 0));
                acc = acc + 1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Order: rst ra ra_rd rb rb_rd s0 rf_s w w_wr daddr d_wr | ra rb alu w zero chk_mrd mrd
        tbl.push_back(mk(1, 1,1, 0,0, 7,0, 1,1, 0,0,  0,0, 1, 1, 0,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 7,0, 1,1, 0,0,  1,0, 2, 2, 0,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 7,0, 1,1, 0,0,  2,0, 3, 3, 0,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 7,0, 1,1, 0,0,  3,0, 4, 4, 0,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 7,0, 1,1, 0,0,  4,0, 5, 5, 0,0,0));
        tbl.push_back(mk(1, 2,1, 0,0, 7,0, 2,1, 0,0,  0,0, 1, 1, 0,0,0));
        tbl.push_back(mk(1, 2,1, 0,0, 7,0, 2,1, 0,0,  1,0, 2, 2, 0,0,0));
        tbl.push_back(mk(1, 2,1, 0,0, 7,0, 2,1, 0,0,  2,0, 3, 3, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 1,0, 4,1, 0,0,  5,3, 8, 8, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 2,0, 5,1, 0,0,  5,3, 2, 2, 0,0,0));
        tbl.push_back(mk(1, 2,1, 1,1, 2,0,10,1, 0,0,  3,5, 'hFFFE,'hFFFE, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 0,0, 0,0, 0,0,  5,3, 0, 0, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 3,0, 0,0, 0,0,  5,3, 5, 5, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 4,0, 0,0, 0,0,  5,3, 6, 6, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 5,0, 0,0, 0,0,  5,3, 7, 7, 0,0,0));
        tbl.push_back(mk(1, 1,1, 2,1, 6,0, 0,0, 0,0,  5,3, 1, 1, 0,0,0));
        tbl.push_back(mk(1, 4,1, 5,1, 5,0, 0,0, 0,0,  8,2,10,10, 0,0,0));
        // store RF[4] to RAM[0x1F], read back, then load into RF[6]
        tbl.push_back(mk(1, 4,1, 0,0, 3,0, 0,0, 'h1F,1,  8,0, 8, 8, 0,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0,0, 'h1F,0,  0,0, 0, 0, 0,1,8));
        tbl.push_back(mk(1, 0,0, 0,0, 0,1, 6,1, 'h1F,0,  0,0, 0, 8, 0,1,8));
        tbl.push_back(mk(1, 6,1, 0,0, 3,0, 0,0, 'h1F,0,  8,0, 8, 8, 0,1,8));
        // zero flag: set by XOR, hold without write, clear on nonzero write
        tbl.push_back(mk(1, 4,1, 4,1, 4,0, 7,1, 0,0,  8,8, 0, 0, 1,0,0));
        tbl.push_back(mk(1, 7,1, 0,0, 3,0, 0,0, 0,0,  0,0, 0, 0, 1,0,0));
        tbl.push_back(mk(1, 7,1, 0,0, 7,0, 8,1, 0,0,  0,0, 1, 1, 0,0,0));
        // RAM same-address store/read: old word first, new word next cycle
        tbl.push_back(mk(1, 8,1, 0,0, 3,0, 0,0, 'h1F,1,  1,0, 1, 1, 0,1,8));
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0,0, 'h1F,0,  0,0, 0, 0, 0,1,1));
        // RF read-during-write: RF[2] gets 0x00AA via load while port A reads it
        tbl.push_back(mk(1,11,1, 0,0, 3,0, 0,0, 'h20,1,  'hAA,0,'hAA,'hAA, 0,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0,0, 'h20,0,  0,0, 0, 0, 0,1,'hAA));
        tbl.push_back(mk(1, 2,1, 0,0, 3,1, 2,1, 'h20,0,  3,0, 3,'hAA, 0,1,'hAA));
        tbl.push_back(mk(1, 2,1, 0,0, 3,0, 0,0, 'h20,0,  'hAA,0,'hAA,'hAA, 0,1,'hAA));
        // read enables low, increment wrap, add overflow, RF[0] is writable
        tbl.push_back(mk(1, 1,0, 2,0, 5,0, 0,0, 0,0,  0,0, 0, 0, 0,0,0));
        tbl.push_back(mk(1,10,1, 0,0, 7,0,12,1, 0,0,  'hFFFE,0,'hFFFF,'hFFFF, 0,0,0));
        tbl.push_back(mk(1,12,1, 0,0, 7,0,13,1, 0,0,  'hFFFF,0, 0, 0, 1,0,0));
        tbl.push_back(mk(1,12,1, 1,1, 1,0, 0,0, 0,0,  'hFFFF,5, 4, 4, 1,0,0));
        tbl.push_back(mk(1,12,1, 0,0, 3,0, 0,1, 0,0,  'hFFFF,0,'hFFFF,'hFFFF, 0,0,0));
        tbl.push_back(mk(1, 0,1, 0,0, 3,0, 0,0, 0,0,  'hFFFF,0,'hFFFF,'hFFFF, 0,0,0));

        Reset = 1'b0; D_addr = 8'd0; D_wr = 1'b0; RF_s = 1'b0;
        RF_W_addr = 4'd0; RF_W_wr = 1'b0; RF_Ra_addr = 4'd3; RF_Ra_rd = 1'b1;
        RF_Rb_addr = 4'd0; RF_Rb_rd = 1'b0; Alu_s0 = 3'd0;
        repeat (2) @(posedge Clock);
        #1;
        chk("init_zero", -1, {15'd0, Zero}, 16'h0000);
        chk("init_mem_rdata", -1, Mem_rdata, 16'h0000);
        chk("init_ra_data", -1, Ra_data, 16'h0000);

        // Reset mid-operation: RF, Zero and Mem_rdata clear; RAM survives and
        // the RF and RAM writes presented on the reset edge are dropped.
        build(3, 16'h1234);
        apply(mk(1, 3,1, 0,0, 3,0, 0,0, 'h40,0,  'h1234,0,'h1234,'h1234, 0,0,0));
        apply(mk(1, 3,1, 0,0, 3,0, 0,0, 'h40,1,  'h1234,0,'h1234,'h1234, 0,0,0));
        apply(mk(1, 0,1, 0,1, 4,0, 9,1, 'h40,0,  0,0, 0, 0, 1,1,'h1234));
        apply(mk(0, 0,1, 0,0, 7,0, 3,1, 'h40,1,  0,0, 1, 1, 0,1,0));
        apply(mk(1, 3,1, 0,0, 3,0, 0,0, 'h40,0,  0,0, 0, 0, 0,1,'h1234));

        build(11, 16'h00AA);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
